// File: rtl/fir_pkg.sv
// Shared types and elaboration-time helpers for the sequential FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_e;

  // Ceiling log2, with a floor of 0 for v <= 1.
  function automatic int fir_clog2(input int v);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Accumulator width: full product width plus growth for TAPS additions.
  function automatic int fir_acc_w(input int n, input int cw, input int taps);
    return n + cw + fir_clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Time-shared multiply-accumulate: one registered multiplier feeding an
// accumulator. The product register adds one cycle between operand
// presentation and the accumulator update.
module fir_mac_unit #(
  parameter int N  = 32,
  parameter int CW = 8,
  parameter int AW = 42
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic signed [N-1:0]  i_x,
  input  logic signed [CW-1:0] i_c,
  output logic signed [AW-1:0] o_acc
);

  localparam int PW  = N + CW;
  localparam int EXT = AW - PW;

  logic signed [PW-1:0] w_x_ext;
  logic signed [PW-1:0] w_c_ext;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] r_prod;
  logic                 r_vld;
  logic signed [AW-1:0] r_acc;

  assign w_x_ext = {{CW{i_x[N-1]}}, i_x};
  assign w_c_ext = {{N{i_c[CW-1]}}, i_c};
  assign w_prod  = w_x_ext * w_c_ext;

  // Capture product when enabled, fold the previous product into the sum.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prod <= '0;
      r_vld  <= 1'b0;
      r_acc  <= '0;
    end else if (i_clr) begin
      r_prod <= '0;
      r_vld  <= 1'b0;
      r_acc  <= '0;
    end else begin
      if (r_vld) begin
        r_acc <= r_acc + {{EXT{r_prod[PW-1]}}, r_prod};
      end
      if (i_en) begin
        r_prod <= w_prod;
      end
      r_vld <= i_en;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fir_seq_mac.sv
// Sequential FIR filter: one multiplier shared across TAPS cycles per sample.
//
// state | meaning
// IDLE  | ready for a sample; coefficient writes allowed
// MAC   | one tap per cycle, tap index ascending from 0
// OUT   | last product drains into the accumulator
//
// Because of the product register, the result is rounded, shifted and
// saturated on the edge after OUT, giving out_valid TAPS+2 cycles after
// the accepting edge.
module fir_seq_mac
  import fir_pkg::*;
#(
  parameter int N    = 32,
  parameter int TAPS = 4,
  parameter int CW   = 8,
  parameter int FRAC = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               data_in,
  input  logic                       coef_we,
  input  logic [fir_clog2(TAPS)-1:0] coef_addr,
  input  logic [CW-1:0]              coef_data,
  output logic                       out_valid,
  output logic [N-1:0]               data_out,
  output logic                       sat
);

  localparam int TW     = fir_clog2(TAPS);
  localparam int AW_ACC = fir_acc_w(N, CW, TAPS);
  localparam int RW     = AW_ACC + 1;
  localparam int RSH    = (FRAC > 0) ? FRAC - 1 : 0;

  localparam logic [TW-1:0]        LAST_TAP = TW'(TAPS - 1);
  localparam logic [TW:0]          TAPS_L   = (TW + 1)'(TAPS);
  localparam logic signed [RW-1:0] RND      = (FRAC > 0) ? (RW'(1) << RSH) : '0;
  localparam logic signed [RW-1:0] MAXV     = {{(RW - N){1'b0}}, 1'b0, {(N - 1){1'b1}}};
  localparam logic signed [RW-1:0] MINV     = {{(RW - N){1'b1}}, 1'b1, {(N - 1){1'b0}}};

  fir_state_e              r_state;
  logic [TW-1:0]           r_tap;
  logic                    r_out_pend;
  logic                    r_out_valid;
  logic [N-1:0]            r_data_out;
  logic                    r_sat;
  logic signed [N-1:0]     r_dline [TAPS];
  logic signed [CW-1:0]    r_coef  [TAPS];

  logic                    w_accept;
  logic                    w_coef_ok;
  logic signed [AW_ACC-1:0] w_acc;
  logic signed [RW-1:0]    w_acc_ext;
  logic signed [RW-1:0]    w_rounded;
  logic signed [RW-1:0]    w_shift;
  logic [N-1:0]            w_res;
  logic                    w_sat;

  assign in_ready  = (r_state == IDLE);
  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_coef_ok = coef_we && (r_state == IDLE) && ({1'b0, coef_addr} < TAPS_L);

  fir_mac_unit #(
    .N  (N),
    .CW (CW),
    .AW (AW_ACC)
  ) u_mac (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (w_accept),
    .i_en    (r_state == MAC),
    .i_x     (r_dline[r_tap]),
    .i_c     (r_coef[r_tap]),
    .o_acc   (w_acc)
  );

  // Delay line: newest sample enters slot 0, oldest falls off the end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) r_dline[i] <= '0;
    end else if (w_accept) begin
      r_dline[0] <= data_in;
      for (int i = 1; i < TAPS; i++) r_dline[i] <= r_dline[i-1];
    end
  end

  // Coefficient file: writes only land while idle and in range.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
    end else if (w_coef_ok) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  // Round half up, arithmetic shift, clip to the signed N-bit range.
  always_comb begin
    w_acc_ext = {w_acc[AW_ACC-1], w_acc};
    w_rounded = w_acc_ext + RND;
    w_shift   = w_rounded >>> FRAC;
    w_sat     = 1'b0;
    w_res     = w_shift[N-1:0];
    if (w_shift > MAXV) begin
      w_sat = 1'b1;
      w_res = {1'b0, {(N - 1){1'b1}}};
    end else if (w_shift < MINV) begin
      w_sat = 1'b1;
      w_res = {1'b1, {(N - 1){1'b0}}};
    end
  end

  // Sequencer plus registered result and one-cycle valid pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_tap       <= '0;
      r_out_pend  <= 1'b0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_out_pend) begin
        r_data_out  <= w_res;
        r_sat       <= w_sat;
        r_out_valid <= 1'b1;
        r_out_pend  <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state <= MAC;
            r_tap   <= '0;
          end
        end
        MAC: begin
          if (r_tap == LAST_TAP) r_state <= OUT;
          else                   r_tap   <= r_tap + TW'(1);
        end
        OUT: begin
          r_state    <= IDLE;
          r_out_pend <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign sat       = r_sat;

endmodule

// File: tb/tb_fir_seq_mac.sv
// Directed bench: default instance A, FRAC=0 instance B, TAPS=3 instance C
// (C shares A's inputs, so its address range check sees the same writes).
module tb_fir_seq_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid;
  logic [31:0] data_in;
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [7:0]  coef_data;

  logic        a_in_ready, a_out_valid, a_sat;
  logic [31:0] a_data_out;
  logic        c_in_ready, c_out_valid, c_sat;
  logic [31:0] c_data_out;

  logic        b_in_valid, b_coef_we;
  logic [31:0] b_data_in;
  logic [1:0]  b_coef_addr;
  logic [7:0]  b_coef_data;
  logic        b_in_ready, b_out_valid, b_sat;
  logic [31:0] b_data_out;

  fir_seq_mac u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .data_in(data_in), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(a_out_valid), .data_out(a_data_out), .sat(a_sat)
  );

  fir_seq_mac #(.N(32), .TAPS(4), .CW(8), .FRAC(0)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .data_in(b_data_in), .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_data(b_coef_data),
    .out_valid(b_out_valid), .data_out(b_data_out), .sat(b_sat)
  );

  fir_seq_mac #(.N(32), .TAPS(3), .CW(8), .FRAC(7)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
    .data_in(data_in), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(c_out_valid), .data_out(c_data_out), .sat(c_sat)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        s;
    int          t;
  } obs_t;

  obs_t qa[$];
  obs_t qb[$];
  obs_t qc[$];

  always @(posedge clk) begin
    #1;
    if (a_out_valid) qa.push_back('{a_data_out, a_sat, cyc});
    if (b_out_valid) qb.push_back('{b_data_out, b_sat, cyc});
    if (c_out_valid) qc.push_back('{c_data_out, c_sat, cyc});
  end

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic wr_coef(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic wr_coef_b(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    b_coef_we = 1'b1; b_coef_addr = a; b_coef_data = d;
    @(negedge clk);
    b_coef_we = 1'b0;
  endtask

  task automatic wait_ready_a();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_in_ready) return;
    end
    timeout_fail("ready_a");
  endtask

  task automatic send_a(input logic [31:0] x, input logic we, input logic [1:0] ca,
                        input logic [7:0] cd, output int t_acc);
    wait_ready_a();
    in_valid = 1'b1; data_in = x;
    coef_we = we; coef_addr = ca; coef_data = cd;
    @(posedge clk);
    #1 t_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] x);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (b_in_ready) break;
    end
    b_in_valid = 1'b1; b_data_in = x;
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  task automatic get_a(output obs_t o);
    for (int k = 0; k < 40; k++) begin
      if (qa.size() > 0) begin
        o = qa.pop_front();
        return;
      end
      @(negedge clk);
    end
    o = '{32'h0, 1'b0, 0};
    timeout_fail("out_a");
  endtask

  task automatic get_b(output obs_t o);
    for (int k = 0; k < 40; k++) begin
      if (qb.size() > 0) begin
        o = qb.pop_front();
        return;
      end
      @(negedge clk);
    end
    o = '{32'h0, 1'b0, 0};
    timeout_fail("out_b");
  endtask

  task automatic pop_c(output obs_t o);
    if (qc.size() > 0) begin
      o = qc.pop_front();
    end else begin
      o = '{32'h0, 1'b0, 0};
      timeout_fail("out_c");
    end
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] ya;
    logic [31:0] yc;
  } vec_t;

  vec_t tv[10];
  logic [31:0] stream[7];

  initial begin
    obs_t o;
    obs_t oc;
    int   ta;
    int   n_acc;
    int   n_low;

    tv[0] = '{32'd100, 32'd25,  32'd25};
    tv[1] = '{32'd0,   32'd25,  32'd25};
    tv[2] = '{32'd0,   32'd25,  32'd25};
    tv[3] = '{32'd0,   32'd25,  32'd0};
    tv[4] = '{32'd0,   32'd0,   32'd0};
    tv[5] = '{32'd128, 32'd32,  32'd32};
    tv[6] = '{32'd128, 32'd64,  32'd64};
    tv[7] = '{32'd128, 32'd96,  32'd96};
    tv[8] = '{32'd128, 32'd128, 32'd96};
    tv[9] = '{32'd128, 32'd128, 32'd96};
    for (int i = 0; i < 7; i++) stream[i] = 32'(2 * (i + 1));

    reset = 1'b0;
    in_valid = 1'b0; data_in = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    b_in_valid = 1'b0; b_data_in = '0; b_coef_we = 1'b0; b_coef_addr = '0; b_coef_data = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, a_in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
    check("rst_data_out", a_data_out, 32'd0);
    check("rst_sat", {31'b0, a_sat}, 32'd0);
    reset = 1'b1;

    // Impulse and step responses, plus C (TAPS=3) ignoring the address-3 write.
    for (int a = 0; a < 4; a++) wr_coef(2'(a), 8'h20);
    for (int i = 0; i < 10; i++) begin
      send_a(tv[i].x, 1'b0, 2'd0, 8'h00, ta);
      get_a(o);
      check($sformatf("vec%0d_data", i), o.d, tv[i].ya);
      check($sformatf("vec%0d_sat", i), {31'b0, o.s}, 32'd0);
      check($sformatf("vec%0d_latency", i), 32'(o.t - ta), 32'd6);
      pop_c(oc);
      check($sformatf("vec%0d_c_data", i), oc.d, tv[i].yc);
    end

    // Coefficient write during MAC must be discarded.
    send_a(32'd256, 1'b0, 2'd0, 8'h00, ta);
    wr_coef(2'd0, 8'h00);
    get_a(o);
    check("macwr_a", o.d, 32'd160);
    pop_c(oc);
    check("macwr_c", oc.d, 32'd128);

    // Write in the accepting cycle applies to that same sample.
    send_a(32'd8, 1'b1, 2'd0, 8'h40, ta);
    get_a(o);
    check("samecyc_a", o.d, 32'd132);
    pop_c(oc);
    check("samecyc_c", oc.d, 32'd100);

    // Negative result: arithmetic shift floors toward minus infinity.
    send_a(32'hFFFFFC18, 1'b0, 2'd0, 8'h00, ta);
    get_a(o);
    check("neg_a", o.d, 32'hFFFFFE6E);
    check("neg_a_sat", {31'b0, o.s}, 32'd0);
    pop_c(oc);
    check("neg_c", oc.d, 32'hFFFFFE4E);

    // Continuous in_valid: y = x/2 with only tap 0 active.
    wr_coef(2'd1, 8'h00);
    wr_coef(2'd2, 8'h00);
    wr_coef(2'd3, 8'h00);
    wait_ready_a();
    qa.delete();
    n_acc = 0;
    n_low = 0;
    for (int i = 0; i < 36; i++) begin
      if (i > 0) @(negedge clk);
      in_valid = 1'b1;
      data_in  = (n_acc < 7) ? stream[n_acc] : 32'd0;
      if (a_in_ready) n_acc++;
      else            n_low++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("stream_accepts", 32'(n_acc), 32'd6);
    check("stream_busy_cycles", 32'(n_low), 32'd30);
    check("stream_count", 32'(qa.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      get_a(o);
      check($sformatf("stream%0d", i), o.d, 32'(i + 1));
    end
    qc.delete();

    // FRAC=0 instance: exact product, then positive and negative clipping.
    for (int a = 0; a < 4; a++) wr_coef_b(2'(a), 8'h7F);
    send_b(32'd5);
    get_b(o);
    check("b_small", o.d, 32'd635);
    check("b_small_sat", {31'b0, o.s}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_b(32'h7FFFFFFF);
      get_b(o);
    end
    check("b_pos_sat_data", o.d, 32'h7FFFFFFF);
    check("b_pos_sat_flag", {31'b0, o.s}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      send_b(32'h80000000);
      get_b(o);
    end
    check("b_neg_sat_data", o.d, 32'h80000000);
    check("b_neg_sat_flag", {31'b0, o.s}, 32'd1);

    // Reset mid-MAC aborts the result and clears coefficients.
    send_a(32'd100, 1'b0, 2'd0, 8'h00, ta);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, a_out_valid}, 32'd0);
    check("midrst_data_out", a_data_out, 32'd0);
    check("midrst_sat", {31'b0, a_sat}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", {31'b0, a_in_ready}, 32'd1);
    repeat (12) @(negedge clk);
    check("midrst_no_pulse", 32'(qa.size()), 32'd0);
    send_a(32'd100, 1'b0, 2'd0, 8'h00, ta);
    get_a(o);
    check("post_rst_impulse", o.d, 32'd0);
    check("post_rst_latency", 32'(o.t - ta), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fir_seq_mac.md
FIR_SEQ_MAC -- requirements
Module: fir_seq_mac

Interface
REQ-001 Parameter N, default 32: data sample width in bits, signed two's complement.
REQ-002 Parameter TAPS, default 4: number of filter taps; legal range 2..64.
REQ-003 Parameter CW, default 8: coefficient width in bits, signed two's complement.
REQ-004 Parameter FRAC, default 7: right-shift applied to the accumulator before output; legal range 0..CW+N-1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  data_in holds a new sample.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 data_in  input  N  input sample.
REQ-010 coef_we  input  1  coefficient write strobe.
REQ-011 coef_addr  input  clog2(TAPS)  coefficient index to write.
REQ-012 coef_data  input  CW  coefficient value.
REQ-013 out_valid  output  1  one-cycle pulse; data_out is new.
REQ-014 data_out  output  N  filtered sample, held between pulses.
REQ-015 sat  output  1  data_out was saturated; valid with out_valid, held until next pulse.

Function
REQ-016 The block SHALL compute y = sum over k = 0..TAPS-1 of c[k]*x[n-k], using one multiplier time-shared over TAPS cycles.
REQ-017 FSM states SHALL be IDLE, MAC and OUT: IDLE->MAC on in_valid&&in_ready; MAC->OUT after tap TAPS-1; OUT->IDLE unconditionally.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 On acceptance the sample SHALL shift into delay-line slot 0, older slots shift by one, the oldest is dropped, and the accumulator clears.
REQ-020 Each MAC cycle SHALL add x[k]*c[k] to the accumulator, k ascending from 0.
REQ-021 The accumulator SHALL be N+CW+clog2(TAPS) bits wide and SHALL never overflow.
REQ-022 In OUT, the result SHALL be formed as: add 2^(FRAC-1) when FRAC>0, arithmetic-shift right by FRAC, then saturate to the signed N-bit range; sat=1 when clipping occurred.
REQ-023 data_out and sat SHALL be registered, and out_valid SHALL pulse for one cycle, TAPS+2 cycles after the accepting edge.
REQ-024 in_valid while busy SHALL be ignored, not queued; the source holds it until in_ready.
REQ-025 coef_we SHALL write c[coef_addr] only in IDLE; writes in MAC/OUT or with coef_addr>=TAPS SHALL be discarded.
REQ-026 Sample acceptance and a coefficient write in the same IDLE cycle SHALL both take effect, and the new coefficient SHALL be used for that sample.

Reset
REQ-027 Asserting reset SHALL at any time force IDLE, zero the delay line, coefficients, accumulator and tap counter, and set data_out=0, sat=0, out_valid=0.
REQ-028 Reset during MAC or OUT SHALL abort the computation with no out_valid pulse; in_ready=1 on the first edge after release.

Structure
REQ-029 Package fir_pkg SHALL hold the FSM state enum, the clog2 helper and the accumulator-width function.
REQ-030 The multiply-accumulate datapath SHALL be one sub-module, fir_mac_unit (operands, clear, enable, accumulator out).
REQ-031 The delay line SHALL be a parametrised register array; the coefficients SHALL be a TAPS x CW register file.

Verification
REQ-032 Defaults, all coefficients 8'h20, impulse 100 then zeros -> outputs 25,25,25,25,0, each out_valid 6 cycles after acceptance.
REQ-033 Defaults, all coefficients 8'h20, constant input 128 -> outputs 32,64,96,128,128.
REQ-034 FRAC=0, all coefficients 8'h7F, input 32'h7FFFFFFF four times -> fourth output 32'h7FFFFFFF with sat=1.
REQ-035 in_valid held high continuously -> in_ready low for 5 of every 6 cycles, exactly one acceptance per 6 cycles, no sample lost or duplicated.
REQ-036 Reset pulsed mid-MAC -> no out_valid, all outputs 0; a later impulse 100 produces 0 (coefficients cleared).
REQ-037 coef_we during MAC, or with coef_addr=TAPS -> coefficient file unchanged; next output matches the old coefficients.
